stack_arb: RTL and testbench
============================

STACK_ARB -- requirements
Module: stack_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: number of wb-busy cycles a pending debug request waits before the pipeline is forced to stall (range 1..255).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wb_push  input  1  writeback stage push request.
REQ-005 SHALL have port wb_to_pop  input  11  writeback stage pop count.
REQ-006 SHALL have port wb_to_push  input  35  writeback stage push data.
REQ-007 SHALL have port dbg_req  input  1  debug requester wants the stack port; held until dbg_ack.
REQ-008 SHALL have port dbg_push, dbg_to_pop[10:0], dbg_to_push[34:0]  input  1/11/35  debug op payload; stable while dbg_req is high.
REQ-009 SHALL have port dbg_ack  output  1  one-cycle pulse: debug op is on the stack port this cycle.
REQ-010 SHALL have port st_push, st_to_pop[10:0], st_to_push[34:0]  output  1/11/35  registered stack update port.
REQ-011 SHALL have port stall_pipe  output  1  stall request to the decode stage.
REQ-012 SHALL have port grant_cnt[15:0], force_cnt[15:0]  output  16 each  statistics (see Configuration).

Function
REQ-013 SHALL treat wb as busy in a cycle when wb_push=1 or wb_to_pop!=0; otherwise as idle.
REQ-014 SHALL register the selected op onto st_* with 1-cycle latency: the op selected in cycle N appears on st_* in cycle N+1.
REQ-015 SHALL always select wb when it is busy; a wb op is never dropped or delayed.
REQ-016 SHALL drive st_push=0 and st_to_pop=0 in the cycle after one in which no op was selected; st_to_push holds its last value.
REQ-017 SHALL implement FSM states IDLE, WAIT, FORCE and ACK.
REQ-018 IDLE transitions: dbg_req=1 with wb idle -> select debug, go to ACK; dbg_req=1 with wb busy -> WAIT, starve counter=1.
REQ-019 WAIT transitions: wb idle -> select debug, go to ACK; wb busy -> counter+1, and go to FORCE when the new value equals STARVE_LIMIT.
REQ-020 FORCE transitions: stall_pipe=1; wb idle -> select debug, go to ACK; otherwise remain in FORCE.
REQ-021 ACK SHALL assert dbg_ack=1, clear the counter, ignore dbg_req, and return to IDLE.
REQ-022 dbg_req falling in WAIT or FORCE SHALL return the FSM to IDLE, clear the counter, and emit no dbg_ack.
REQ-023 stall_pipe SHALL be a Moore output, high exactly while the state is FORCE.
REQ-024 A debug op with push=0 and pop=0 SHALL still be granted and acknowledged.

Reset
REQ-025 rst_b low SHALL immediately force: state IDLE, counter 0, st_push=0, st_to_pop=0, st_to_push=0, dbg_ack=0, stall_pipe=0, grant_cnt=0, force_cnt=0.
REQ-026 Reset mid-request SHALL discard the pending debug op with no dbg_ack; the requester must re-request.

Configuration
REQ-027 With STACK_ARB_STATS_EN defined, grant_cnt SHALL increment on every ACK cycle, and force_cnt SHALL increment on every entry into FORCE.
REQ-028 Both counters SHALL be 16-bit and saturate at 16'hFFFF.
REQ-029 Without STACK_ARB_STATS_EN, grant_cnt and force_cnt SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-030 dbg_req=1, push=1, to_push=35'h5 with wb idle at cycle 0 -> st_push=1 and st_to_push=5 at cycle 1; dbg_ack=1 at cycle 1 only.
REQ-031 wb_push=1 every cycle, dbg_req=1, STARVE_LIMIT=8 -> stall_pipe rises after the 8th busy cycle; after wb goes idle, the debug op is on st_* and dbg_ack pulses on the next cycle.
REQ-032 wb_to_pop=2 and dbg_req in the same cycle from IDLE -> st_to_pop=2 next cycle, state WAIT, no dbg_ack.
REQ-033 rst_b asserted while in FORCE -> stall_pipe=0 and all outputs 0 at once; no dbg_ack after release.
REQ-034 With STACK_ARB_STATS_EN, 3 grants of which 1 forced -> grant_cnt=3, force_cnt=1; without the macro, both read 0.

Source files
------------

// File: rtl/stack_arb_if.sv
// stack_arb_if -- bundle of the writeback, debug and stack-update signals
// shared between the stack port arbiter and its surroundings.
// The slave modport is the arbiter's view; the master modport is the view
// of whoever drives the writeback/debug requests and consumes the results.
interface stack_arb_if;
    // Writeback stage request
    logic        wb_push;
    logic [10:0] wb_to_pop;
    logic [34:0] wb_to_push;

    // Debug requester
    logic        dbg_req;
    logic        dbg_push;
    logic [10:0] dbg_to_pop;
    logic [34:0] dbg_to_push;
    logic        dbg_ack;

    // Registered stack update port and pipeline control
    logic        st_push;
    logic [10:0] st_to_pop;
    logic [34:0] st_to_push;
    logic        stall_pipe;

    // Statistics
    logic [15:0] grant_cnt;
    logic [15:0] force_cnt;

    modport slave (
        input  wb_push, wb_to_pop, wb_to_push,
        input  dbg_req, dbg_push, dbg_to_pop, dbg_to_push,
        output dbg_ack,
        output st_push, st_to_pop, st_to_push, stall_pipe,
        output grant_cnt, force_cnt
    );

    modport master (
        output wb_push, wb_to_pop, wb_to_push,
        output dbg_req, dbg_push, dbg_to_pop, dbg_to_push,
        input  dbg_ack,
        input  st_push, st_to_pop, st_to_push, stall_pipe,
        input  grant_cnt, force_cnt
    );
endinterface

// File: rtl/stack_arb.sv
// stack_arb -- arbitrates the single stack update port between the
// writeback stage (always wins) and a debug requester. A debug request that
// is starved by writeback traffic for STARVE_LIMIT busy cycles forces a
// pipeline stall so writeback eventually goes idle and debug gets through.
//
// Optional feature: define STACK_ARB_STATS_EN to build saturating 16-bit
// grant / forced-stall statistics counters. Without it both counters read 0
// and no counter flops are built.
module stack_arb #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_b,
    stack_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t      state;
    logic [7:0]  starve_cnt;
    logic [8:0]  cnt_inc;

    logic        st_push_q;
    logic [10:0] st_to_pop_q;
    logic [34:0] st_to_push_q;
    logic        dbg_ack_q;
    logic        stall_q;

    logic        wb_busy;
    logic        dbg_sel;
    logic        force_entry;

    // Decode writeback activity, debug selection and entry into FORCE.
    always_comb begin
        wb_busy     = bus.wb_push | (bus.wb_to_pop != 11'd0);
        cnt_inc     = {1'b0, starve_cnt} + 9'd1;
        // Debug is only picked when writeback leaves the port free; the ACK
        // cycle ignores dbg_req so a still-high request is not granted twice.
        dbg_sel     = !wb_busy && bus.dbg_req && (state != ACK);
        // A limit of 1 means the very first busy cycle already exhausts it.
        force_entry = bus.dbg_req && wb_busy &&
                      (((state == IDLE) && (LIMIT <= 8'd1)) ||
                       ((state == WAIT) && (cnt_inc >= {1'b0, LIMIT})));
    end

    // Arbitration FSM with the registered stack port, dbg_ack and stall.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state        <= IDLE;
            starve_cnt   <= 8'd0;
            st_push_q    <= 1'b0;
            st_to_pop_q  <= 11'd0;
            st_to_push_q <= 35'd0;
            dbg_ack_q    <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            // Stack port: writeback has absolute priority, then debug,
            // otherwise a no-op with the data bus left unchanged.
            if (wb_busy) begin
                st_push_q    <= bus.wb_push;
                st_to_pop_q  <= bus.wb_to_pop;
                st_to_push_q <= bus.wb_to_push;
            end else if (dbg_sel) begin
                st_push_q    <= bus.dbg_push;
                st_to_pop_q  <= bus.dbg_to_pop;
                st_to_push_q <= bus.dbg_to_push;
            end else begin
                st_push_q    <= 1'b0;
                st_to_pop_q  <= 11'd0;
            end

            // dbg_ack coincides with the debug op appearing on st_*.
            dbg_ack_q <= dbg_sel;
            stall_q   <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.dbg_req) begin
                        if (!wb_busy) begin
                            state <= ACK;
                        end else if (force_entry) begin
                            state      <= FORCE;
                            starve_cnt <= 8'd1;
                            stall_q    <= 1'b1;
                        end else begin
                            state      <= WAIT;
                            starve_cnt <= 8'd1;
                        end
                    end
                end
                WAIT: begin
                    if (!bus.dbg_req) begin
                        state      <= IDLE;
                        starve_cnt <= 8'd0;
                    end else if (!wb_busy) begin
                        state <= ACK;
                    end else begin
                        starve_cnt <= cnt_inc[7:0];
                        if (force_entry) begin
                            state   <= FORCE;
                            stall_q <= 1'b1;
                        end
                    end
                end
                FORCE: begin
                    if (!bus.dbg_req) begin
                        state      <= IDLE;
                        starve_cnt <= 8'd0;
                    end else if (!wb_busy) begin
                        state <= ACK;
                    end else begin
                        stall_q <= 1'b1;
                    end
                end
                ACK: begin
                    state      <= IDLE;
                    starve_cnt <= 8'd0;
                end
                default: begin
                    state      <= IDLE;
                    starve_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign bus.st_push    = st_push_q;
    assign bus.st_to_pop  = st_to_pop_q;
    assign bus.st_to_push = st_to_push_q;
    assign bus.dbg_ack    = dbg_ack_q;
    assign bus.stall_pipe = stall_q;

`ifdef STACK_ARB_STATS_EN
    logic [15:0] grant_q;
    logic [15:0] force_q;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Statistics: one grant per ACK cycle, one force per entry into FORCE.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            grant_q <= 16'd0;
            force_q <= 16'd0;
        end else begin
            if (state == ACK) begin
                grant_q <= sat_inc16(grant_q);
            end
            if (force_entry) begin
                force_q <= sat_inc16(force_q);
            end
        end
    end

    assign bus.grant_cnt = grant_q;
    assign bus.force_cnt = force_q;
`else
    assign bus.grant_cnt = 16'd0;
    assign bus.force_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_stack_arb.sv
// tb_stack_arb -- scoreboard bench for stack_arb. Each stimulus cycle queues
// the stack-port response expected one cycle later; a monitor on the falling
// edge pops and compares entries stamped for the current cycle.
module tb_stack_arb;

    logic clk;
    logic rst_b;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct {
        int          at;
        string       name;
        logic        push;
        logic [10:0] pop;
        logic [34:0] data;
        logic        ack;
        logic        stall;
    } exp_t;

    exp_t sb[$];

    stack_arb_if bus ();

    stack_arb #(.STARVE_LIMIT(8)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: compare every queued expectation due in this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".st_push"},    64'(bus.st_push),    64'(e.push));
            chk({e.name, ".st_to_pop"},  64'(bus.st_to_pop),  64'(e.pop));
            chk({e.name, ".st_to_push"}, 64'(bus.st_to_push), 64'(e.data));
            chk({e.name, ".dbg_ack"},    64'(bus.dbg_ack),    64'(e.ack));
            chk({e.name, ".stall_pipe"}, 64'(bus.stall_pipe), 64'(e.stall));
        end
    end

    // Drive one cycle of inputs and queue the response due next cycle.
    task automatic step(input string name,
                        input logic wp, input logic [10:0] wpop, input logic [34:0] wd,
                        input logic dr, input logic dp, input logic [10:0] dpop, input logic [34:0] dd,
                        input logic e_push, input logic [10:0] e_pop, input logic [34:0] e_data,
                        input logic e_ack, input logic e_stall);
        exp_t e;
        bus.wb_push     = wp;
        bus.wb_to_pop   = wpop;
        bus.wb_to_push  = wd;
        bus.dbg_req     = dr;
        bus.dbg_push    = dp;
        bus.dbg_to_pop  = dpop;
        bus.dbg_to_push = dd;
        e.at    = cyc + 1;
        e.name  = name;
        e.push  = e_push;
        e.pop   = e_pop;
        e.data  = e_data;
        e.ack   = e_ack;
        e.stall = e_stall;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".st_push"},    64'(bus.st_push),    64'd0);
        chk({name, ".st_to_pop"},  64'(bus.st_to_pop),  64'd0);
        chk({name, ".st_to_push"}, 64'(bus.st_to_push), 64'd0);
        chk({name, ".dbg_ack"},    64'(bus.dbg_ack),    64'd0);
        chk({name, ".stall_pipe"}, 64'(bus.stall_pipe), 64'd0);
        chk({name, ".grant_cnt"},  64'(bus.grant_cnt),  64'd0);
        chk({name, ".force_cnt"},  64'(bus.force_cnt),  64'd0);
    endtask

    initial begin
        logic [15:0] exp_grants;
        logic [15:0] exp_forces;
        cyc      = 0;
        checks   = 0;
        failures = 0;
        rst_b    = 1'b0;
        bus.wb_push = 1'b0;  bus.wb_to_pop = '0;  bus.wb_to_push = '0;
        bus.dbg_req = 1'b0;  bus.dbg_push = 1'b0; bus.dbg_to_pop = '0; bus.dbg_to_push = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_b = 1'b1;

        // Debug op with writeback idle: granted next cycle, one ack pulse.
        step("dbg_idle",  0, 11'd0, 35'd0, 1, 1, 11'd0, 35'h5,  1, 11'd0, 35'h5, 1, 0);
        step("dbg_idle2", 0, 11'd0, 35'd0, 0, 0, 11'd0, 35'h0,  0, 11'd0, 35'h5, 0, 0);

        // Writeback pop collides with a debug request: wb wins, debug waits.
        step("wb_pop",    0, 11'd2, 35'h7, 1, 0, 11'd3, 35'h9,  0, 11'd2, 35'h7, 0, 0);
        step("wait_gnt",  0, 11'd0, 35'h0, 1, 0, 11'd3, 35'h9,  0, 11'd3, 35'h9, 1, 0);
        step("wait_gnt2", 0, 11'd0, 35'h0, 0, 0, 11'd0, 35'h0,  0, 11'd0, 35'h9, 0, 0);

        // Starvation: stall rises after the 8th busy cycle, then debug wins.
        for (int i = 0; i < 10; i++) begin
            step($sformatf("starve%0d", i), 1, 11'd0, 35'(100 + i), 1, 1, 11'd0, 35'h4_0000_0001,
                 1, 11'd0, 35'(100 + i), 0, (i >= 7));
        end
        step("force_gnt",  0, 11'd0, 35'h0, 1, 1, 11'd0, 35'h4_0000_0001, 1, 11'd0, 35'h4_0000_0001, 1, 0);
        step("force_gnt2", 0, 11'd0, 35'h0, 0, 0, 11'd0, 35'h0,           0, 11'd0, 35'h4_0000_0001, 0, 0);

        // Request withdrawn while waiting: no grant, no ack.
        step("withdraw0", 1, 11'd0, 35'h20, 1, 1, 11'd1, 35'h55, 1, 11'd0, 35'h20, 0, 0);
        step("withdraw1", 0, 11'd0, 35'h0,  0, 0, 11'd0, 35'h0,  0, 11'd0, 35'h20, 0, 0);
        step("withdraw2", 0, 11'd0, 35'h0,  0, 0, 11'd0, 35'h0,  0, 11'd0, 35'h20, 0, 0);

`ifdef STACK_ARB_STATS_EN
        exp_grants = 16'd3;
        exp_forces = 16'd1;
`else
        exp_grants = 16'd0;
        exp_forces = 16'd0;
`endif
        chk("grant_cnt", 64'(bus.grant_cnt), 64'(exp_grants));
        chk("force_cnt", 64'(bus.force_cnt), 64'(exp_forces));

        // A debug no-op (no push, no pop) is still granted and acked.
        step("dbg_nop",  0, 11'd0, 35'h0, 1, 0, 11'd0, 35'h33, 0, 11'd0, 35'h33, 1, 0);
        step("dbg_nop2", 0, 11'd0, 35'h0, 0, 0, 11'd0, 35'h0,  0, 11'd0, 35'h33, 0, 0);

        // Drive into FORCE, then reset asynchronously mid-cycle.
        for (int i = 0; i < 9; i++) begin
            step($sformatf("starveB%0d", i), 1, 11'd0, 35'(200 + i), 1, 0, 11'd4, 35'h66,
                 1, 11'd0, 35'(200 + i), 0, (i >= 7));
        end
        @(negedge clk);
        #1;
        rst_b = 1'b0;
        bus.wb_push = 1'b0;
        bus.dbg_req = 1'b0;
        #1;
        chk_all_zero("rst_force");
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        step("post_rst0", 0, 11'd0, 35'h0, 0, 0, 11'd0, 35'h0, 0, 11'd0, 35'h0, 0, 0);
        step("post_rst1", 0, 11'd0, 35'h0, 0, 0, 11'd0, 35'h0, 0, 11'd0, 35'h0, 0, 0);

        @(negedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the stimulus never completes.
    initial begin
        #100000;
        $display("FAIL timeout actual=%0d required=done", cyc);
        $fatal(1, "timeout");
    end

endmodule
